// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch controller for a single-issue MIPS-style core.
// Owns the PC, drives the combinational instruction memory, registers fetched
// words into a valid/ready IF/ID slot, resolves J-type jumps locally, applies
// EX-stage branch redirects and halts once the PC runs past the program end.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] MAX_PC   = 32'd11,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_data,
  output logic [31:0]      if_instr,
  output logic [31:0]      if_pc,
  output logic             if_valid,
  input  logic             id_ready,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             halt,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  localparam logic [5:0] OP_J = 6'b000010;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      ifpc_q, ifpc_d;
  logic             valid_q, valid_d;
  logic             halt_q, halt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             slot_free_s;
  logic             handshake_s;
  logic [31:0]      pc_p1_s;
  logic             is_jump_s;

  // Handshake / slot-availability and next-sequential-PC helpers.
  always_comb begin
    slot_free_s = !valid_q || id_ready;
    handshake_s = valid_q && id_ready;
    pc_p1_s     = pc_q + 32'd1;
    is_jump_s   = (imem_data[31:26] == OP_J);
  end

  // Next-state logic: redirect beats the halt check, which beats a fetch;
  // otherwise everything holds and the slot only drains through a handshake.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    halt_d  = halt_q;
    cnt_d   = cnt_q;
    if (handshake_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    if (redirect_valid) begin
      // Wrong-path instruction in the slot is dropped; no fetch this cycle.
      pc_d    = redirect_pc;
      valid_d = 1'b0;
      state_d = ST_RUN;
      halt_d  = 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (en && slot_free_s) begin
            if (pc_q > MAX_PC) begin
              state_d = ST_HALT;
              halt_d  = 1'b1;
            end else begin
              instr_d = imem_data;
              ifpc_d  = pc_q;
              valid_d = 1'b1;
              if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
              end else begin
                cnt_d = cnt_q;
              end
              // J-type target keeps the upper bits of PC+1; the jump word
              // itself is still delivered to decode.
              if (is_jump_s) begin
                pc_d = {pc_p1_s[31:26], imem_data[25:0]};
              end else begin
                pc_d = pc_p1_s;
              end
            end
          end else begin
            pc_d = pc_q;
          end
        end
        ST_HALT: begin
          pc_d = pc_q;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // Sequencer state and output-slot registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      ifpc_q  <= 32'd0;
      valid_q <= 1'b0;
      halt_q  <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      valid_q <= valid_d;
      halt_q  <= halt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_instr    = instr_q;
  assign if_pc       = ifpc_q;
  assign if_valid    = valid_q;
  assign halt        = halt_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed stimulus pushes the expected
// handshake order; a negedge monitor pops and compares each accepted slot.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_valid;
  logic        id_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [15:0] fetch_count;

  int total;
  int bad;
  logic [31:0] exp_q[$];

  fetch_sequencer #(.RESET_PC(32'd0), .MAX_PC(32'd11), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid),
    .id_ready(id_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt), .fetch_count(fetch_count)
  );

  // Program image: word 5 is a J to address 8, everything else is a non-jump.
  function automatic logic [31:0] prog(input logic [31:0] a);
    if (a == 32'd5) return 32'h0800_0008;
    return 32'h2000_0000 | a;
  endfunction

  assign imem_data = prog(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc);
    exp_q.push_back(pc);
  endtask

  // Monitor: every completed handshake must match the next expected pc/instr.
  always @(negedge clk) begin
    if (!rst && if_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_handshake: got pc %0h expected none", if_pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("hs_pc", if_pc, e);
        chk("hs_instr", if_instr, prog(e));
      end
    end
  end

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    en = 1'b0;
    id_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    tick();
    tick();
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_halt", {31'd0, halt}, 32'd0);
    chk("rst_cnt", {16'd0, fetch_count}, 32'd0);
    chk("rst_pc", imem_addr, 32'd0);
    chk("rst_ifpc", if_pc, 32'd0);
    chk("rst_instr", if_instr, 32'd0);

    // Straight-line fetch with a backpressure window on pc 2, then the jump.
    foreach (prog_a[i]) push(prog_a[i]);
    rst = 1'b0;
    en = 1'b1;
    id_ready = 1'b1;
    tick();
    chk("first_valid", {31'd0, if_valid}, 32'd1);
    chk("first_pc", if_pc, 32'd0);
    tick();
    tick();
    chk("bp_start_pc", if_pc, 32'd2);
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_pc", if_pc, 32'd2);
      chk("bp_instr", if_instr, prog(32'd2));
      chk("bp_valid", {31'd0, if_valid}, 32'd1);
      chk("bp_fetch_pc", imem_addr, 32'd3);
      chk("bp_cnt", {16'd0, fetch_count}, 32'd3);
    end
    id_ready = 1'b1;
    tick();
    chk("bp_release_pc", if_pc, 32'd3);
    tick();
    chk("cnt_after_4", {16'd0, fetch_count}, 32'd5);
    tick();
    chk("jump_word", if_instr, 32'h0800_0008);
    chk("jump_target", imem_addr, 32'd8);
    tick();
    chk("jump_no_bubble", if_pc, 32'd8);
    chk("jump_valid", {31'd0, if_valid}, 32'd1);
    tick();
    chk("pc9", if_pc, 32'd9);

    // Redirect while stalled: pc 9 is discarded without a handshake.
    foreach (prog_b[i]) push(prog_b[i]);
    id_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'd1;
    tick();
    chk("redir_bubble", {31'd0, if_valid}, 32'd0);
    chk("redir_pc", imem_addr, 32'd1);
    redirect_valid = 1'b0;
    id_ready = 1'b1;
    tick();
    chk("redir_target", if_pc, 32'd1);
    chk("redir_target_valid", {31'd0, if_valid}, 32'd1);
    for (int i = 0; i < 8; i++) tick();
    chk("last_pc", if_pc, 32'd11);

    // Run past the end of the program.
    tick();
    chk("halt_rise", {31'd0, halt}, 32'd1);
    chk("halt_valid", {31'd0, if_valid}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("halt_hold", {31'd0, halt}, 32'd1);
      chk("halt_pc", imem_addr, 32'd12);
      chk("halt_novalid", {31'd0, if_valid}, 32'd0);
    end
    chk("halt_cnt", {16'd0, fetch_count}, 32'd17);

    // Leave HALT through a redirect to 0, then redirect again to 6.
    push(32'd0); push(32'd1); push(32'd2); push(32'd6);
    redirect_valid = 1'b1;
    redirect_pc = 32'd0;
    tick();
    chk("halt_fall", {31'd0, halt}, 32'd0);
    chk("halt_exit_bubble", {31'd0, if_valid}, 32'd0);
    chk("halt_exit_pc", imem_addr, 32'd0);
    redirect_valid = 1'b0;
    tick();
    chk("halt_exit_first", if_pc, 32'd0);
    chk("halt_exit_valid", {31'd0, if_valid}, 32'd1);
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'd6;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick();
    chk("pc7", if_pc, 32'd7);

    // Async reset between edges with a concurrent redirect.
    id_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'd3;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, if_valid}, 32'd0);
    chk("arst_pc", imem_addr, 32'd0);
    chk("arst_cnt", {16'd0, fetch_count}, 32'd0);
    chk("arst_halt", {31'd0, halt}, 32'd0);
    tick();
    chk("arst_redir_lost", imem_addr, 32'd0);
    redirect_valid = 1'b0;
    rst = 1'b0;
    id_ready = 1'b1;
    push(32'd0); push(32'd1);
    tick();
    chk("post_rst_pc", if_pc, 32'd0);
    chk("post_rst_fetch", imem_addr, 32'd1);
    tick();
    tick();
    id_ready = 1'b0;
    chk("post_rst_cnt", {16'd0, fetch_count}, 32'd3);
    tick();
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  logic [31:0] prog_a[7] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd8};
  logic [31:0] prog_b[9] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd8, 32'd9, 32'd10, 32'd11};

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller for the single-issue MIPS-style core. It owns the program counter and drives the word address of the combinational instruction memory. It registers each fetched word into a valid/ready IF/ID output slot and resolves J-type jumps in the fetch stage. It also applies branch redirects from the execute stage and stops fetching once the PC runs past the last program word.

## Interface
- RESET_PC, 0, PC loaded on reset (word address).
- MAX_PC, 11, last valid program word address; fetch beyond it halts.
- CNT_W, 16, width of the fetch counter.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  fetch enable; 0 freezes PC and counter, output slot still drains.
- imem_addr  out  32  word address to instruction memory; equals PC combinationally.
- imem_data  in  32  instruction word returned combinationally for imem_addr.
- if_instr  out  32  registered instruction.
- if_pc  out  32  registered address of if_instr.
- if_valid  out  1  output slot holds an instruction.
- id_ready  in  1  decode accepts the slot this cycle.
- redirect_valid  in  1  taken branch from EX; one-cycle pulse.
- redirect_pc  in  32  redirect target (word address).
- halt  out  1  sequencer is in HALT.
- fetch_count  out  CNT_W  instructions loaded into the slot, saturating.

## Operation
- The sequencer has two states, RUN and HALT. It leaves reset in RUN.
- slot_free = !if_valid || id_ready. Handshake completes when if_valid && id_ready.
- Priority each cycle: rst > redirect_valid > halt check > fetch > hold.
- **Redirect (any state):**
  - PC <= redirect_pc and if_valid <= 0; a valid instruction held in the slot is discarded as wrong-path.
  - State <= RUN and halt <= 0.
  - No fetch happens in the redirect cycle.
- **RUN, en=1, slot_free, PC > MAX_PC:** state <= HALT, halt <= 1. No capture, so if_valid <= 0 if the slot was consumed.
- **RUN, en=1, slot_free, PC <= MAX_PC (fetch):**
  - if_instr <= imem_data, if_pc <= PC, if_valid <= 1.
  - fetch_count increments, saturating at all-ones.
- **Next-PC on fetch:**
  - If imem_data[31:26] == 6'b000010 (J): PC <= {PCp1[31:26], imem_data[25:0]}, where PCp1 = PC+1. The jump word itself is still emitted in the slot.
  - Otherwise PC <= PC+1, 32-bit wrap.
- **RUN, en=0 or slot not free:** PC, slot and counter hold. if_valid drops only through a handshake, with no refill.
- **HALT:** PC frozen, no fetch, halt=1. A slot already valid stays until accepted. Only redirect or rst leaves HALT.
- Slot contents never change while if_valid=1 && id_ready=0.

## Timing
- Reset (async, immediate): PC=RESET_PC, if_instr=0, if_pc=0, if_valid=0, halt=0, fetch_count=0, state=RUN.
- First instruction: if_valid=1 after the first rising edge with rst=0 and en=1.
- Throughput: one instruction per cycle while en=1 and id_ready=1.
- Jumps cost no bubble; the target is fetched on the next edge.
- Redirect latency:
  - Edge N samples redirect_valid: slot empty in cycle N+1.
  - Target instruction valid after edge N+1: one bubble.
- Halt:
  - halt rises on the edge after the free-slot cycle in which PC > MAX_PC.
  - After a redirect, halt falls on the redirect edge.
- rst asserted mid-stream clears everything asynchronously. A redirect pending in the same cycle is lost.

## Test plan
- Straight-line fetch: program words 0-4 loaded, id_ready=1, en=1 -> if_pc 0,1,2,3,4 on consecutive cycles; if_valid=1 throughout; fetch_count=5.
- Jump: address 5 holds 32'h08000008 -> if_pc 5 followed directly by if_pc 8, with no bubble; addresses 6-7 are never emitted.
- Backpressure: id_ready=0 for 3 cycles while if_pc=2 -> if_instr/if_pc stay stable, PC stays 3, and fetch_count does not advance; after id_ready=1, if_pc=3 follows next cycle.
- Redirect while stalled: slot holds pc 9, id_ready=0, redirect_valid=1 with redirect_pc=1 -> if_valid=0 next cycle, if_pc=1 the cycle after; the pc 9 word is never handshaken.
- Halt: run past MAX_PC=11 -> after if_pc=11 is accepted, halt=1, if_valid=0, PC=12 frozen for 10 cycles; then redirect_pc=0 -> halt=0 and if_pc=0 valid two edges later.
- Async reset mid-run: assert rst between clock edges at if_pc=7 -> if_valid=0, PC=0, fetch_count=0 immediately; a concurrent redirect is ignored.
